mem_burst_responder: RTL and testbench
======================================

// Module: mem_burst_responder
// PURPOSE
//  Main-memory side of the cache<->memory block interface. It is the responder to a
//  cache controller that initiates transfers with rd_mem, wr_mem and addr_mem, and
//  that paces itself on ready_mem.
//  It serves block reads (refill) and block writes (write-back) of BLOCKSIZE bytes,
//  one byte per cycle, over a byte lane. It holds a behavioural byte-wide storage array.
// PARAMETERS
//  AWIDTH      9    byte address width; array depth is 2**AWIDTH bytes
//  DWIDTH      8    data lane width (one byte)
//  BLOCKSIZE   4    bytes per burst; power of 2, >=2
//  RD_LATENCY  2    idle cycles between read accept and first read byte; 0..15
// PORTS
//  clock        in   1       single clock, all logic on rising edge
//  reset        in   1       synchronous, active-high
//  addr_mem     in   AWIDTH  burst address; low log2(BLOCKSIZE) bits ignored (forced 0)
//  rd_mem       in   1       block read request, sampled only while ready_mem=1
//  wr_mem       in   1       block write request, sampled only while ready_mem=1
//  wdata_mem    in   DWIDTH  write byte lane from cache
//  rdata_mem    out  DWIDTH  read byte lane to cache (registered)
//  rdata_oe     out  1       drive enable for top-level tri-state of data_mem; =rdata_valid
//  rdata_valid  out  1       rdata_mem holds a valid burst byte this cycle
//  ready_mem    out  1       1 = idle, can accept a request; 0 = burst in progress
// BEHAVIOUR
//  Reset (clock edge with reset=1): state=IDLE, ready_mem=1, rdata_valid=0, rdata_oe=0,
//   rdata_mem=0, byte counter=0, latched block address=0. Array contents NOT cleared.
//   A reset during any burst aborts it immediately. Bytes already written stay written.
//  FSM states: IDLE, RD_WAIT, RD_BURST, WR_BURST.
//  IDLE: ready_mem=1. On an edge with ready_mem=1:
//   - wr_mem=1 (regardless of rd_mem; write has priority): latch block addr, cnt=0, go to WR_BURST.
//   - else rd_mem=1: latch block addr, cnt=0. Go to RD_WAIT, or go to RD_BURST if RD_LATENCY=0.
//   ready_mem deasserts on the accepting edge.
//  RD_WAIT: count RD_LATENCY cycles, then go to RD_BURST.
//  RD_BURST: on each edge, rdata_mem <= mem[{blk,cnt}], rdata_valid <= 1, cnt++.
//   Byte 0 (lowest address) goes first.
//   First valid byte is registered on edge RD_LATENCY+1 after the accepting edge.
//   The BLOCKSIZE bytes occupy BLOCKSIZE consecutive cycles with no gaps.
//   The edge after the last byte sets rdata_valid=0, ready_mem=1 and state=IDLE.
//  WR_BURST: wdata_mem is sampled on edges 1..BLOCKSIZE after the accepting edge.
//   Each sampled byte is written to mem[{blk,cnt}] on that same edge, in order byte 0 first.
//   ready_mem returns to 1 on the edge that samples the last byte. The next cycle is idle.
//  rd_mem/wr_mem are ignored while ready_mem=0. No queuing; requests are not level-held.
//  Address arithmetic: byte address = {addr_mem[AWIDTH-1:log2(BLOCKSIZE)], cnt}.
//   The counter never carries into the block field, so a burst wraps within its block only.
//   The top block (e.g. 0x1FC..0x1FF) is legal.
//  Read-after-write: a read accepted in the cycle after a write burst ends returns the new data.
//  cnt width = log2(BLOCKSIZE). The latency counter is 4 bits.
// TESTING
//  1 Reset, then wr_mem=1 with addr=0x025 and bytes 11,22,33,44 on edges 1-4
//    -> mem[0x024..0x027]=11,22,33,44; ready_mem=0 for 4 cycles, then back to 1.
//  2 rd_mem=1 with addr=0x026 after test 1, RD_LATENCY=2 -> rdata_valid high on edges 3-6
//    with 11,22,33,44; ready_mem=1 on edge 7; rdata_oe tracks rdata_valid exactly.
//  3 rd_mem=1 and wr_mem=1 together with addr=0x1FC -> a write burst is taken; no read
//    bytes appear; mem[0x1FC..0x1FF] are updated; no wrap into 0x000.
//  4 During a read burst, pulse rd_mem and wr_mem with addr=0x040 -> both are ignored; the
//    burst finishes unchanged; no second burst starts.
//  5 Assert reset on the 2nd read byte cycle -> next edge gives rdata_valid=0 and
//    ready_mem=1; a following read of the same block returns the original array data.
//  6 Rebuild with RD_LATENCY=0 and read 0x024 -> first valid byte on edge 1 after accept;
//    the data is 11,22,33,44 back-to-back.

Source files
------------

// File: rtl/mem_burst_responder.sv
// Memory-side responder for cache block transfers: one byte per cycle over a byte lane.
// Serves BLOCKSIZE-byte read (refill) and write (write-back) bursts from a byte-wide array.
module mem_burst_responder #(
    parameter int AWIDTH     = 9,
    parameter int DWIDTH     = 8,
    parameter int BLOCKSIZE  = 4,
    parameter int RD_LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [AWIDTH-1:0] addr_mem,
    input  logic              rd_mem,
    input  logic              wr_mem,
    input  logic [DWIDTH-1:0] wdata_mem,
    output logic [DWIDTH-1:0] rdata_mem,
    output logic              rdata_oe,
    output logic              rdata_valid,
    output logic              ready_mem,
    output logic [1:0]        fsm_state
);

    localparam int CW = $clog2(BLOCKSIZE);
    localparam int BW = AWIDTH - CW;
    localparam logic [CW-1:0] CNT_LAST = CW'(BLOCKSIZE - 1);
    localparam logic [3:0]    LAT_LAST = (RD_LATENCY == 0) ? 4'd0 : 4'(RD_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
        RD_BURST = 2'd2,
        WR_BURST = 2'd3
    } state_t;

    state_t state, state_next;

    logic [DWIDTH-1:0] mem [0:(1<<AWIDTH)-1];
    logic [BW-1:0]     blk;
    logic [CW-1:0]     cnt;
    logic [3:0]        lat_cnt;
    logic              rd_done;
    logic [AWIDTH-1:0] byte_addr;

    logic accept, lat_inc, rd_en, rd_finish, wr_en;

    // Handshake: a request (rd_mem/wr_mem) is taken only on an edge where ready_mem=1;
    // at any other time it is dropped. rdata_mem is meaningful only while rdata_valid=1.
    assign ready_mem = (state == IDLE);
    assign rdata_oe  = rdata_valid;
    assign fsm_state = state;
    assign byte_addr = {blk, cnt};

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        lat_inc    = 1'b0;
        rd_en      = 1'b0;
        rd_finish  = 1'b0;
        wr_en      = 1'b0;
        case (state)
            IDLE: begin
                if (wr_mem) begin
                    accept     = 1'b1;
                    state_next = WR_BURST;
                end else if (rd_mem) begin
                    accept     = 1'b1;
                    state_next = (RD_LATENCY == 0) ? RD_BURST : RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (lat_cnt == LAT_LAST) state_next = RD_BURST;
                else                     lat_inc    = 1'b1;
            end
            RD_BURST: begin
                // rd_done marks that the last byte went out on the previous edge
                if (rd_done) begin
                    rd_finish  = 1'b1;
                    state_next = IDLE;
                end else begin
                    rd_en = 1'b1;
                end
            end
            WR_BURST: begin
                wr_en = 1'b1;
                if (cnt == CNT_LAST) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            blk         <= '0;
            cnt         <= '0;
            lat_cnt     <= '0;
            rd_done     <= 1'b0;
            rdata_mem   <= '0;
            rdata_valid <= 1'b0;
        end else begin
            if (accept) begin
                blk     <= addr_mem[AWIDTH-1:CW];
                cnt     <= '0;
                lat_cnt <= '0;
                rd_done <= 1'b0;
            end
            if (lat_inc) lat_cnt <= lat_cnt + 4'd1;
            if (rd_en) begin
                rdata_mem   <= mem[byte_addr];
                rdata_valid <= 1'b1;
                cnt         <= cnt + 1'b1;
                rd_done     <= (cnt == CNT_LAST);
            end
            if (rd_finish) begin
                rdata_valid <= 1'b0;
                rd_done     <= 1'b0;
            end
            if (wr_en) cnt <= cnt + 1'b1;
        end
    end

    // Array is never cleared; a reset edge suppresses the write so an aborted burst stops at once.
    always_ff @(posedge clock) begin
        if (wr_en && !reset) mem[byte_addr] <= wdata_mem;
    end

endmodule

// File: tb/tb_mem_burst_responder.sv
// Bench for mem_burst_responder: one instance with RD_LATENCY=2, one with RD_LATENCY=0,
// sharing clock/reset; sel picks which instance the driver tasks talk to.
module tb_mem_burst_responder;

    localparam int AW = 9;
    localparam int DW = 8;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset;
    logic [AW-1:0] addr;
    logic          rd, wr, sel;
    logic [DW-1:0] wdata;

    logic          rd2, wr2, rd0, wr0;
    logic [DW-1:0] rdata2, rdata0, rdata;
    logic          oe2, oe0, oe, valid2, valid0, valid, ready2, ready0, ready;
    logic [1:0]    st2, st0;

    assign rd2   = rd & ~sel;
    assign wr2   = wr & ~sel;
    assign rd0   = rd & sel;
    assign wr0   = wr & sel;
    assign rdata = sel ? rdata0 : rdata2;
    assign oe    = sel ? oe0    : oe2;
    assign valid = sel ? valid0 : valid2;
    assign ready = sel ? ready0 : ready2;

    mem_burst_responder #(.AWIDTH(AW), .DWIDTH(DW), .BLOCKSIZE(4), .RD_LATENCY(2)) dut (
        .clock(clock), .reset(reset), .addr_mem(addr), .rd_mem(rd2), .wr_mem(wr2),
        .wdata_mem(wdata), .rdata_mem(rdata2), .rdata_oe(oe2), .rdata_valid(valid2),
        .ready_mem(ready2), .fsm_state(st2));

    mem_burst_responder #(.AWIDTH(AW), .DWIDTH(DW), .BLOCKSIZE(4), .RD_LATENCY(0)) dut_lat0 (
        .clock(clock), .reset(reset), .addr_mem(addr), .rd_mem(rd0), .wr_mem(wr0),
        .wdata_mem(wdata), .rdata_mem(rdata0), .rdata_oe(oe0), .rdata_valid(valid0),
        .ready_mem(ready0), .fsm_state(st0));

    logic [DW-1:0] model [0:1][0:511];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_byte;
    int passed = 0;
    int total  = 0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard: every valid byte from either instance must match the head of exp_q.
    always @(negedge clock) begin
        if (valid2 || valid0) begin
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL rdata_unexpected got=%h expected=none", rdata);
            end else begin
                exp_byte = exp_q.pop_front();
                if (rdata !== exp_byte)
                    $display("FAIL rdata got=%h expected=%h", rdata, exp_byte);
                else passed++;
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        total++; if (ready2 !== 1'b1 || ready0 !== 1'b1) $display("FAIL reset_ready got=%b%b expected=11", ready2, ready0); else passed++;
        total++; if (valid2 !== 1'b0 || oe2 !== 1'b0 || valid0 !== 1'b0) $display("FAIL reset_valid got=%b%b%b expected=000", valid2, oe2, valid0); else passed++;
        total++; if (rdata2 !== 8'h00 || rdata0 !== 8'h00) $display("FAIL reset_rdata got=%h/%h expected=00/00", rdata2, rdata0); else passed++;
        total++; if (st2 !== 2'd0 || st0 !== 2'd0) $display("FAIL reset_state got=%0d/%0d expected=0/0", st2, st0); else passed++;
    endtask

    task automatic test_write(input logic [AW-1:0] a_in, input logic [31:0] bytes, input logic also_rd);
        logic [AW-1:0] a;
        addr = a_in;
        wr   = 1'b1;
        rd   = also_rd;
        tick();
        wr = 1'b0;
        rd = 1'b0;
        total++; if (ready !== 1'b0) $display("FAIL wr_ready_accept got=%b expected=0", ready); else passed++;
        for (int i = 0; i < 4; i++) begin
            a = {a_in[AW-1:2], 2'(i)};
            wdata = bytes[8*i +: 8];
            model[sel][a] = bytes[8*i +: 8];
            tick();
            total++; if (ready !== (i == 3)) $display("FAIL wr_ready byte=%0d got=%b expected=%b", i, ready, (i == 3)); else passed++;
            total++; if (valid !== 1'b0) $display("FAIL wr_no_rdata byte=%0d got=%b expected=0", i, valid); else passed++;
        end
    endtask

    task automatic test_read(input logic [AW-1:0] a_in, input int lat, input logic poke);
        logic exp_v;
        for (int i = 0; i < 4; i++) exp_q.push_back(model[sel][{a_in[AW-1:2], 2'(i)}]);
        addr = a_in;
        rd   = 1'b1;
        tick();
        rd = 1'b0;
        for (int k = 1; k <= lat + 5; k++) begin
            if (poke && k == lat + 2) begin
                rd = 1'b1; wr = 1'b1; addr = 9'h040; wdata = 8'hEE;
            end
            if (poke && k == lat + 3) begin
                rd = 1'b0; wr = 1'b0;
            end
            tick();
            exp_v = (k >= lat + 1) && (k <= lat + 4);
            total++; if (valid !== exp_v) $display("FAIL rd_valid edge=%0d got=%b expected=%b", k, valid, exp_v); else passed++;
            total++; if (oe !== exp_v) $display("FAIL rd_oe edge=%0d got=%b expected=%b", k, oe, exp_v); else passed++;
            total++; if (ready !== (k == lat + 5)) $display("FAIL rd_ready edge=%0d got=%b expected=%b", k, ready, (k == lat + 5)); else passed++;
        end
        total++; if (exp_q.size() != 0) $display("FAIL rd_bytes_missing got=%0d expected=0", exp_q.size()); else passed++;
    endtask

    task automatic test_ignored_requests();
        test_read(9'h024, 2, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (valid !== 1'b0 || ready !== 1'b1) $display("FAIL ignore_idle cycle=%0d got=%b%b expected=01", k, valid, ready); else passed++;
        end
    endtask

    task automatic test_reset_mid_read();
        exp_q.push_back(model[0][9'h024]);
        exp_q.push_back(model[0][9'h025]);
        addr = 9'h024;
        rd   = 1'b1;
        tick();
        rd = 1'b0;
        for (int k = 1; k <= 4; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (valid !== 1'b0 || oe !== 1'b0) $display("FAIL midreset_valid got=%b%b expected=00", valid, oe); else passed++;
        total++; if (ready !== 1'b1) $display("FAIL midreset_ready got=%b expected=1", ready); else passed++;
        total++; if (rdata !== 8'h00) $display("FAIL midreset_rdata got=%h expected=00", rdata); else passed++;
        total++; if (exp_q.size() != 0) $display("FAIL midreset_bytes got=%0d expected=0", exp_q.size()); else passed++;
        test_read(9'h024, 2, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a;
        test_write(9'h100, 32'h78563412, 1'b0);
        test_read(9'h102, 2, 1'b0);
        for (int n = 0; n < 4; n++) begin
            a = 9'($urandom_range(0, 511));
            test_write(a, $urandom, 1'b0);
            test_read(9'($urandom_range(0, 3)) | {a[AW-1:2], 2'b00}, 2, 1'b0);
        end
    endtask

    task automatic test_lat0();
        sel = 1'b1;
        test_write(9'h024, 32'h44332211, 1'b0);
        test_read(9'h024, 0, 1'b0);
        test_read(9'h027, 0, 1'b0);
        sel = 1'b0;
    endtask

    initial begin
        sel = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; reset = 1'b1;
        test_reset();
        test_write(9'h025, 32'h44332211, 1'b0);
        test_read(9'h026, 2, 1'b0);
        test_write(9'h000, 32'hDDCCBBAA, 1'b0);
        test_write(9'h1FC, 32'hEFBEADDE, 1'b1);
        test_read(9'h1FF, 2, 1'b0);
        test_read(9'h000, 2, 1'b0);
        test_ignored_requests();
        test_reset_mid_read();
        test_back_to_back();
        test_lat0();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
